// File: rtl/dequantiser.sv
`default_nettype none
// ============================================================================
// Module   : dequantiser
// Purpose  : Serial JPEG dequantisation. Accepts 64 quantised coefficients in
//            zig-zag order, multiplies each by its luminance quantisation step
//            with signed saturation, stores them in raster position, then
//            drains the 8x8 block in raster order.
// Ports    : clk, reset (async, active-high), en (global enable)
//            in_valid / in_ready / in_data   : zig-zag coefficient stream
//            out_valid / out_ready / out_data: raster coefficient stream
//            out_index (row*8+col), out_last (index 63), out_sat (clamped)
// Revision : 1.0 - initial release
// ============================================================================
module dequantiser #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [5:0]   out_index,
    output logic         out_last,
    output logic         out_sat
);

    localparam logic [0:0] c_FILL  = 1'b0;
    localparam logic [0:0] c_DRAIN = 1'b1;

    // Luminance quantisation table, raster order.
    localparam logic [7:0] c_Q_TABLE [0:63] = '{
        8'd16,  8'd11,  8'd10,  8'd16,  8'd24,  8'd40,  8'd51,  8'd61,
        8'd12,  8'd12,  8'd14,  8'd19,  8'd26,  8'd58,  8'd60,  8'd55,
        8'd14,  8'd13,  8'd16,  8'd24,  8'd40,  8'd57,  8'd69,  8'd56,
        8'd14,  8'd17,  8'd22,  8'd29,  8'd51,  8'd87,  8'd80,  8'd62,
        8'd18,  8'd22,  8'd37,  8'd56,  8'd68,  8'd109, 8'd103, 8'd77,
        8'd24,  8'd35,  8'd55,  8'd64,  8'd81,  8'd104, 8'd113, 8'd92,
        8'd49,  8'd64,  8'd78,  8'd87,  8'd103, 8'd121, 8'd120, 8'd101,
        8'd72,  8'd92,  8'd95,  8'd98,  8'd112, 8'd100, 8'd103, 8'd99
    };

    // Zig-zag sequence number -> raster position.
    localparam logic [5:0] c_ZIGZAG [0:63] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    logic [0:0]     r_state;
    logic [5:0]     r_wr_cnt;
    logic [5:0]     r_rd_cnt;
    logic [W-1:0]   r_buf [0:63];
    logic           r_sat [0:63];

    logic [0:0]     w_state_nxt;
    logic [5:0]     w_wr_cnt_nxt;
    logic [5:0]     w_rd_cnt_nxt;
    logic           w_in_fire;
    logic           w_out_fire;
    logic [5:0]     w_raster;
    logic [7:0]     w_q;
    logic [W+8:0]   w_a;
    logic [W+8:0]   w_b;
    logic [W+8:0]   w_prod;
    logic [9:0]     w_hi;
    logic           w_ovf;
    logic [W-1:0]   w_clamped;

    // Multiply at W+9 bits: sign-extended data times zero-extended step.
    // The product fits in range only when its top 10 bits are all equal.
    assign w_raster  = c_ZIGZAG[r_wr_cnt];
    assign w_q       = c_Q_TABLE[w_raster];
    assign w_a       = {{9{in_data[W-1]}}, in_data};
    assign w_b       = {{W{1'b0}}, {1'b0, w_q}};
    assign w_prod    = w_a * w_b;
    assign w_hi      = w_prod[W+8:W-1];
    assign w_ovf     = !((&w_hi) || !(|w_hi));
    assign w_clamped = !w_ovf       ? w_prod[W-1:0] :
                       w_prod[W+8]  ? {1'b1, {(W-1){1'b0}}} :
                                      {1'b0, {(W-1){1'b1}}};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= c_FILL;
            r_wr_cnt <= 6'd0;
            r_rd_cnt <= 6'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_wr_cnt <= w_wr_cnt_nxt;
            r_rd_cnt <= w_rd_cnt_nxt;
        end
    end

    // Block storage is never cleared: each fill overwrites all 64 entries
    // before the drain reads any of them.
    always_ff @(posedge clk) begin
        if (w_in_fire) begin
            r_buf[w_raster] <= w_clamped;
            r_sat[w_raster] <= w_ovf;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_wr_cnt_nxt = r_wr_cnt;
        w_rd_cnt_nxt = r_rd_cnt;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        out_data     = '0;
        out_sat      = 1'b0;
        out_last     = 1'b0;
        out_index    = r_rd_cnt;

        // Reset gating keeps the handshake signals low while reset is held,
        // regardless of en.
        if (r_state == c_FILL) begin
            in_ready = en && !reset;
        end else begin
            out_valid = en && !reset;
        end

        if (out_valid) begin
            out_data = r_buf[r_rd_cnt];
            out_sat  = r_sat[r_rd_cnt];
            out_last = (r_rd_cnt == 6'd63);
        end

        w_in_fire  = in_valid && in_ready;
        w_out_fire = out_valid && out_ready;

        if (w_in_fire) begin
            w_wr_cnt_nxt = r_wr_cnt + 6'd1;
            if (r_wr_cnt == 6'd63) begin
                w_state_nxt = c_DRAIN;
            end
        end

        if (w_out_fire) begin
            w_rd_cnt_nxt = r_rd_cnt + 6'd1;
            if (r_rd_cnt == 6'd63) begin
                w_state_nxt = c_FILL;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dequantiser.sv
`default_nettype none
// ============================================================================
// Module   : tb_dequantiser
// Purpose  : Directed self-checking bench for dequantiser.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dequantiser;

    logic        clk;
    logic        reset;
    logic        en;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [5:0]  out_index;
    logic        out_last;
    logic        out_sat;

    int checks   = 0;
    int failures = 0;

    logic [31:0] got  [0:63];
    logic        gsat [0:63];

    dequantiser #(.W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_index (out_index),
        .out_last  (out_last),
        .out_sat   (out_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // mode 0: value v at k=0, zero elsewhere; mode 1: ramp k+1
    function automatic logic [31:0] gen(input int mode, input int k, input logic [31:0] v);
        if (mode == 1) return 32'(k + 1);
        return (k == 0) ? v : 32'd0;
    endfunction

    task automatic fill(input int mode, input logic [31:0] v, input int nin, input bit freeze);
        for (int k = 0; k < nin; k++) begin
            @(negedge clk);
            if (freeze && k == 20) begin
                en       = 1'b0;
                in_valid = 1'b1;
                in_data  = 32'h1234_5678;
                repeat (10) @(negedge clk);
                #1;
                chk("freeze_fill_in_ready", in_ready, 0);
                chk("freeze_fill_out_valid", out_valid, 0);
                en = 1'b1;
            end
            in_valid = 1'b1;
            in_data  = gen(mode, k, v);
            #1;
            if (k == 0)  chk("fill_in_ready", in_ready, 1);
            if (k == 63) chk("pre_last_out_valid", out_valid, 0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 32'd0;
        #1;
        if (nin == 64) begin
            chk("latency_out_valid", out_valid, 1);
            chk("latency_out_index", out_index, 0);
        end
    endtask

    task automatic drain(input bit stall, input bit freeze);
        int          beats = 0;
        int          cyc = 0;
        bit          froze = 0;
        bit          pstall = 0;
        bit          bad_ready = 0;
        bit          bad_hold = 0;
        bit          bad_last = 0;
        logic [5:0]  pidx = 6'd0;
        logic [31:0] pdata = 32'd0;
        logic [5:0]  sidx;
        for (int i = 0; i < 64; i++) begin
            got[i]  = 32'hDEAD_BEEF;
            gsat[i] = 1'bx;
        end
        while (beats < 64 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (freeze && beats == 30 && !froze) begin
                froze = 1;
                sidx  = out_index;
                en    = 1'b0;
                #1;
                chk("freeze_drain_out_valid", out_valid, 0);
                chk("freeze_drain_out_data", out_data, 0);
                repeat (10) @(negedge clk);
                chk("freeze_drain_index_held", out_index, sidx);
                en = 1'b1;
            end
            #1;
            if (in_ready) bad_ready = 1;
            if (out_valid) begin
                if (pstall && (out_index !== pidx || out_data !== pdata)) bad_hold = 1;
                if (out_last !== (out_index == 6'd63)) bad_last = 1;
                out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
                if (out_ready) begin
                    got[out_index]  = out_data;
                    gsat[out_index] = out_sat;
                    beats++;
                    pstall = 0;
                end else begin
                    pstall = 1;
                    pidx   = out_index;
                    pdata  = out_data;
                end
            end
        end
        chk("drain_beats", beats, 64);
        chk("drain_in_ready_low", bad_ready, 0);
        chk("drain_hold_stable", bad_hold, 0);
        chk("drain_out_last", bad_last, 0);
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        chk("drain_done_out_valid", out_valid, 0);
    endtask

    task automatic check_ramp(input string tag);
        chk({tag, "_r0"},  got[0],  32'd16);
        chk({tag, "_r1"},  got[1],  32'd22);
        chk({tag, "_r8"},  got[8],  32'd36);
        chk({tag, "_r16"}, got[16], 32'd56);
        chk({tag, "_r63"}, got[63], 32'd6336);
    endtask

    initial begin
        int nz;
        int cyc;
        reset     = 1'b1;
        en        = 1'b1;
        in_valid  = 1'b0;
        in_data   = 32'd0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_index", out_index, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_sat", out_sat, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("post_rst_in_ready", in_ready, 1);

        // DC-only block
        fill(0, 32'd5, 64, 0);
        drain(0, 0);
        chk("dc_r0", got[0], 32'd80);
        chk("dc_r0_sat", gsat[0], 0);
        nz = 0;
        for (int i = 1; i < 64; i++) if (got[i] !== 32'd0 || gsat[i] !== 1'b0) nz++;
        chk("dc_ac_zero", nz, 0);

        // Ramp with random back-pressure
        fill(1, 32'd0, 64, 0);
        drain(1, 0);
        check_ramp("ramp");

        // Saturation
        fill(0, 32'h7FFF_FFFF, 64, 0);
        drain(0, 0);
        chk("sat_pos", got[0], 32'h7FFF_FFFF);
        chk("sat_pos_flag", gsat[0], 1);
        chk("sat_pos_r1_flag", gsat[1], 0);
        fill(0, 32'hF000_0000, 64, 0);
        drain(0, 0);
        chk("sat_neg", got[0], 32'h8000_0000);
        chk("sat_neg_flag", gsat[0], 1);
        fill(0, 32'hFFFF_FFFD, 64, 0);
        drain(0, 0);
        chk("neg_small", got[0], 32'hFFFF_FFD0);
        chk("neg_small_flag", gsat[0], 0);

        // Enable freeze mid-fill and mid-drain
        fill(1, 32'd0, 64, 1);
        drain(0, 1);
        check_ramp("freeze");

        // Reset after 30 inputs
        fill(1, 32'd0, 30, 0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midfill_rst_in_ready", in_ready, 0);
        @(negedge clk);
        reset = 1'b0;
        fill(1, 32'd0, 64, 0);
        drain(0, 0);
        check_ramp("rst_fill");

        // Reset during drain at index 20
        fill(0, 32'd5, 64, 0);
        out_ready = 1'b1;
        cyc = 0;
        while (out_index != 6'd20 && cyc < 200) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        chk("reach_index20", out_index, 20);
        out_ready = 1'b0;
        reset = 1'b1;
        #1;
        chk("middrain_rst_out_valid", out_valid, 0);
        chk("middrain_rst_out_index", out_index, 0);
        @(negedge clk);
        reset = 1'b0;
        fill(0, 32'd7, 64, 0);
        drain(0, 0);
        chk("after_rst_r0", got[0], 32'd112);
        chk("after_rst_r1", got[1], 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dequantiser.md
# dequantiser

Serial JPEG dequantisation stage for the decoder path, the inverse of the compressor's quantise and float-to-fix back end. It accepts one block of 64 quantised, fixed-point DCT coefficients in zig-zag order over a valid/ready stream. Each coefficient is multiplied by its luminance quantisation step and written to an internal 8x8 buffer in raster (row-major) position. The reconstructed block then drains in raster order to the downstream inverse-DCT stage.

## Interface
- W, 32: coefficient width, input and output, signed two's complement integer.
- clk  in  1  rising-edge clock; the only clock.
- reset  in  1  asynchronous, active-high; clears all state.
- en  in  1  global enable; low freezes the block.
- in_valid  in  1  in_data holds a coefficient.
- in_ready  out  1  block accepts in_data this cycle.
- in_data  in  W  quantised coefficient, zig-zag order, k = 0..63.
- out_valid  out  1  out_data holds a dequantised coefficient.
- out_ready  in  1  downstream accepts out_data.
- out_data  out  W  dequantised coefficient, raster order.
- out_index  out  6  raster index of out_data (row*8+col).
- out_last  out  1  high with out_index = 63 while out_valid.
- out_sat  out  1  this coefficient was clamped during multiplication.

## Operation
- Quant table Q[r], r = raster index, is the ITU-T T.81 Annex K Table K.1 luminance table, hardwired as 8-bit unsigned constants.
  - Check values: Q[0]=16, Q[1]=11, Q[8]=12, Q[63]=99.
- Zig-zag map zz[k] to raster is the standard T.81 order.
  - Check values: zz[0]=0, zz[1]=1, zz[2]=8, zz[3]=16, zz[4]=9, zz[5]=2, zz[63]=63.
- Two-state FSM, FILL and DRAIN. Reset state is FILL with both counters at 0.
- FILL:
  - in_ready = en; out_valid = 0.
  - On handshake (in_valid & in_ready), write buffer[zz[wr_cnt]] with the saturated product in_data * Q[zz[wr_cnt]], store the sat bit, then increment wr_cnt.
  - Handshake with wr_cnt = 63: wr_cnt wraps to 0 and the FSM goes to DRAIN.
- DRAIN:
  - in_ready = 0; out_valid = en; out_index = rd_cnt; out_data = buffer[rd_cnt]; out_sat = satbit[rd_cnt].
  - On handshake, increment rd_cnt.
  - Handshake with rd_cnt = 63: rd_cnt wraps to 0 and the FSM goes to FILL.
- Arithmetic:
  - Product is computed at W+9 bits as signed in_data times zero-extended 8-bit Q.
  - Clamp to [-2^(W-1), 2^(W-1)-1]; sat = 1 if clamped.
- Whenever out_valid = 0: out_data = 0, out_sat = 0, out_last = 0.
- en low: no handshakes, no counter or state changes, buffer holds its contents.
- Buffer contents are not reset. Every entry is overwritten before it is read, because all 64 raster positions are written each FILL.

## Timing
- Reset values of outputs: in_ready 0 while reset is asserted, then en; out_valid 0, out_data 0, out_index 0, out_last 0, out_sat 0.
- Input to output latency:
  - The 64th input handshake occurs in cycle N.
  - out_valid = 1 (given en) in cycle N+1, with out_index 0.
- Throughput: 128 cycles per block minimum, with no overlap between fill and drain.
- out_data is a combinational read of the registered buffer and is stable while out_valid & !out_ready.
- Downstream holds: out_valid stays high and out_index stays constant until out_ready.
- Reset mid-block, in either state: everything returns to FILL with counters 0. The partially received or partially drained block is discarded; the next accepted coefficient is k = 0.
- in_valid during DRAIN is ignored, because in_ready = 0.

## Test plan
- DC-only block: in_data = 5 at k=0, 0 for k=1..63 -> out_index 0 gives 80; indices 1..63 give 0; out_last only at index 63; out_valid rises exactly 1 cycle after the 64th accept.
- Ramp: in_data = k+1 -> raster 0 = 16, raster 1 = 22, raster 8 = 36 (3*12), raster 16 = 56 (4*14), raster 63 = 6336 (64*99).
- Saturation:
  - k=0 in_data = 0x7FFFFFFF -> out 0x7FFFFFFF, out_sat = 1.
  - k=0 in_data = -2^28 -> out 0x80000000, out_sat = 1.
  - k=0 in_data = -3 -> out -48, out_sat = 0.
- Back-pressure: out_ready randomly toggled during DRAIN -> out_data and out_index held while stalled; in_ready = 0 throughout DRAIN; exactly 64 output beats.
- Enable freeze: en = 0 for 10 cycles mid-FILL and mid-DRAIN -> in_ready and out_valid are 0 and counters are unchanged; the results match the unfrozen run.
- Reset mid-operation: reset after 30 inputs, then a full 64-input ramp -> output equals the plain ramp case; reset during DRAIN at index 20 -> out_valid drops asynchronously and the next block starts at k = 0.
